// File: rtl/mode_seq_ctrl.sv
// Mode sequencer: LOAD / COUNT / ENUM control FSM driving accumulator y and step counter s.
// All outputs come from registers or a decode of the state register.
module mode_seq_ctrl #(
    parameter int unsigned W          = 8,
    parameter int unsigned SW         = 3,
    parameter int unsigned CNT_STEP   = 1,
    parameter int unsigned ENUM_START = 6,
    parameter int unsigned ENUM_STEP  = 2,
    parameter int unsigned DWELL      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  x,
    input  logic [1:0]    on,
    input  logic          start,
    output logic [W-1:0]  y,
    output logic [SW-1:0] s,
    output logic          b,
    output logic [1:0]    regime,
    output logic          active,
    output logic          done
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0] DWELL_RELOAD = DW'(DWELL - 1);
    localparam logic [SW-1:0] CNT_DEC      = SW'(CNT_STEP);
    localparam logic [SW-1:0] ENUM_DEC     = SW'(ENUM_STEP);
    localparam logic [SW-1:0] ENUM_INIT    = SW'(ENUM_START);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_L0    = 3'd1;
    localparam logic [2:0] ST_L1    = 3'd2;
    localparam logic [2:0] ST_L2    = 3'd3;
    localparam logic [2:0] ST_CNT   = 3'd4;
    localparam logic [2:0] ST_EWAIT = 3'd5;
    localparam logic [2:0] ST_ERUN  = 3'd6;

    logic [2:0]    r_state;
    logic [W-1:0]  r_y;
    logic [SW-1:0] r_s;
    logic          r_b;
    logic          r_active;
    logic          r_done;
    logic [DW-1:0] r_dwell;

    logic [2:0]    w_state_nxt;
    logic [W-1:0]  w_y_nxt;
    logic [SW-1:0] w_s_nxt;
    logic          w_b_nxt;
    logic          w_active_nxt;
    logic          w_done_nxt;
    logic [DW-1:0] w_dwell_nxt;

    logic [W:0]    w_sum;
    logic          w_cnt_borrow;
    logic          w_enum_last;

    assign w_sum        = {1'b0, r_y} + {1'b0, x};
    assign w_cnt_borrow = (r_s < CNT_DEC);
    assign w_enum_last  = (r_s < ENUM_DEC);

    always_comb begin
        w_state_nxt  = r_state;
        w_y_nxt      = r_y;
        w_s_nxt      = r_s;
        w_b_nxt      = r_b;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
        w_dwell_nxt  = r_dwell;
        case (r_state)
            ST_OFF: begin
                case (on)
                    2'd3: w_state_nxt = ST_L0;
                    2'd2: w_state_nxt = ST_CNT;
                    2'd1: begin
                        w_state_nxt = ST_EWAIT;
                        w_b_nxt     = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_L0: begin
                w_y_nxt     = x;
                w_state_nxt = ST_L1;
            end
            ST_L1: begin
                {w_b_nxt, w_y_nxt} = w_sum;
                w_s_nxt            = r_s - SW'(1);
                w_state_nxt        = ST_L2;
            end
            ST_L2: begin
                w_state_nxt = ST_OFF;
                w_done_nxt  = 1'b1;
            end
            ST_CNT: begin
                if (start) begin
                    w_s_nxt = r_s - CNT_DEC;
                    // Borrow out of s carries into the accumulator
                    if (w_cnt_borrow) begin
                        w_y_nxt = r_y + W'(1);
                        w_b_nxt = 1'b1;
                    end else begin
                        w_b_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_OFF;
                    w_b_nxt     = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_EWAIT: begin
                if (!start) begin
                    w_s_nxt      = ENUM_INIT;
                    w_dwell_nxt  = DWELL_RELOAD;
                    w_active_nxt = 1'b1;
                    w_state_nxt  = ST_ERUN;
                end
            end
            ST_ERUN: begin
                if (r_dwell != '0) begin
                    w_dwell_nxt = r_dwell - DW'(1);
                end else if (!w_enum_last) begin
                    w_s_nxt     = r_s - ENUM_DEC;
                    w_dwell_nxt = DWELL_RELOAD;
                end else begin
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_OFF;
                end
            end
            default: begin
                w_state_nxt  = ST_OFF;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_OFF;
            r_y      <= '0;
            r_s      <= '0;
            r_b      <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_y      <= w_y_nxt;
            r_s      <= w_s_nxt;
            r_b      <= w_b_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
            r_dwell  <= w_dwell_nxt;
        end
    end

    always_comb begin
        case (r_state)
            ST_L0, ST_L1, ST_L2: regime = 2'd3;
            ST_CNT:              regime = 2'd2;
            ST_EWAIT, ST_ERUN:   regime = 2'd1;
            default:             regime = 2'd0;
        endcase
    end

    assign y      = r_y;
    assign s      = r_s;
    assign b      = r_b;
    assign active = r_active;
    assign done   = r_done;

endmodule

// File: tb/tb_mode_seq_ctrl.sv
// Bench for mode_seq_ctrl: vector table through a scoreboard queue on the default build,
// plus hand-written ENUM runs on a wide build.
module tb_mode_seq_ctrl;

    typedef struct {
        logic       rst;
        logic [1:0] on;
        logic       start;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
        logic [1:0] regime;
        logic       active;
        logic       done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, b, active, done;
    logic [1:0]  on, regime;
    logic [7:0]  x, y;
    logic [2:0]  s;

    logic        rst2, start2, b2, active2, done2;
    logic [1:0]  on2, regime2;
    logic [11:0] x2, y2;
    logic [3:0]  s2;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    mode_seq_ctrl u_dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .on     (on),
        .start  (start),
        .y      (y),
        .s      (s),
        .b      (b),
        .regime (regime),
        .active (active),
        .done   (done)
    );

    mode_seq_ctrl #(
        .W          (12),
        .SW         (4),
        .CNT_STEP   (1),
        .ENUM_START (13),
        .ENUM_STEP  (3),
        .DWELL      (1)
    ) u_dut2 (
        .clk    (clk),
        .rst    (rst2),
        .x      (x2),
        .on     (on2),
        .start  (start2),
        .y      (y2),
        .s      (s2),
        .b      (b2),
        .regime (regime2),
        .active (active2),
        .done   (done2)
    );

    function automatic vec_t mk(logic r, logic [1:0] o, logic st, logic [7:0] xi,
                                logic [7:0] ey, logic [2:0] es, logic eb, logic [1:0] erg,
                                logic ea, logic ed);
        vec_t v;
        v.rst = r; v.on = o; v.start = st; v.x = xi;
        v.y = ey; v.s = es; v.b = eb; v.regime = erg; v.active = ea; v.done = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        int   exp_s2 [5] = '{13, 10, 7, 4, 1};

        rst = 1'b0; on = 2'd0; start = 1'b0; x = 8'h00;
        rst2 = 1'b0; on2 = 2'd0; start2 = 1'b0; x2 = 12'h000;

        //                rst on st  x      | y    s b rg a d
        // Reset with random inputs, then idle
        vecs.push_back(mk(0, 2'($urandom), 1'($urandom), 8'($urandom), 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'($urandom), 1'($urandom), 8'($urandom), 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h55, 8'h00, 0, 0, 0, 0, 0));
        // LOAD with x=0x90; start and on ignored inside
        vecs.push_back(mk(1, 3, 0, 8'h90, 8'h00, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h90, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 2, 1, 8'h90, 8'h20, 7, 1, 3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h20, 7, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h20, 7, 1, 0, 0, 0));
        // COUNT: entry edge does not decrement; on toggled 1/3 to confirm masking
        vecs.push_back(mk(1, 2, 1, 8'h90, 8'h20, 7, 1, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h90, 8'h20, 6, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 1, 8'h90, 8'h20, 5, 0, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h90, 8'h20, 4, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 1, 8'h90, 8'h20, 3, 0, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h90, 8'h20, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 1, 8'h90, 8'h20, 1, 0, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h90, 8'h20, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 1, 8'h90, 8'h21, 7, 1, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h90, 8'h21, 6, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 6, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 6, 0, 0, 0, 0));
        // ENUM: five cycles waiting with start high, then 8 active cycles
        vecs.push_back(mk(1, 1, 1, 8'h90, 8'h21, 6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3, 1, 8'h90, 8'h21, 6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 1, 8'h90, 8'h21, 6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h21, 6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h21, 6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 6, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h21, 6, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 4, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h21, 4, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 2, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h21, 2, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 8'h90, 8'h21, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 0, 0, 0, 0, 0));
        // Reset during the third ERUN cycle: no done pulse afterwards
        vecs.push_back(mk(1, 1, 0, 8'h90, 8'h21, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 6, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 6, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h21, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h90, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h90, 8'h00, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; on = vecs[i].on; start = vecs[i].start; x = vecs[i].x;
            exp_q.push_back(vecs[i]);
            tick();
            e = exp_q.pop_front();
            chk("y", i, 32'(y), 32'(e.y));
            chk("s", i, 32'(s), 32'(e.s));
            chk("b", i, 32'(b), 32'(e.b));
            chk("regime", i, 32'(regime), 32'(e.regime));
            chk("active", i, 32'(active), 32'(e.active));
            chk("done", i, 32'(done), 32'(e.done));
        end

        // Wide build: full ENUM run 13,10,7,4,1 with single-cycle dwell
        rst = 1'b1; on = 2'd0; start = 1'b0;
        rst2 = 1'b0;
        tick();
        chk("w_reset_s", 0, 32'(s2), 0);
        chk("w_reset_regime", 0, 32'(regime2), 0);
        rst2 = 1'b1; on2 = 2'd1; start2 = 1'b0;
        tick();
        chk("w_ewait_regime", 0, 32'(regime2), 1);
        chk("w_ewait_active", 0, 32'(active2), 0);
        on2 = 2'd0;
        for (int k = 0; k < 5; k++) begin
            start2 = 1'($urandom);
            if (k == 0) start2 = 1'b0;
            tick();
            chk("w_run_s", k, 32'(s2), 32'(exp_s2[k]));
            chk("w_run_active", k, 32'(active2), 1);
            chk("w_run_done", k, 32'(done2), 0);
        end
        tick();
        chk("w_end_done", 0, 32'(done2), 1);
        chk("w_end_regime", 0, 32'(regime2), 0);
        chk("w_end_s", 0, 32'(s2), 1);
        chk("w_end_active", 0, 32'(active2), 0);
        tick();
        chk("w_end_done_clr", 0, 32'(done2), 0);

        // Wide build: reset in third ERUN cycle
        on2 = 2'd1; start2 = 1'b0;
        tick();
        on2 = 2'd0;
        tick();
        tick();
        tick();
        chk("w_mid_s", 0, 32'(s2), 7);
        rst2 = 1'b0;
        tick();
        chk("w_rst_s", 0, 32'(s2), 0);
        chk("w_rst_regime", 0, 32'(regime2), 0);
        chk("w_rst_active", 0, 32'(active2), 0);
        chk("w_rst_done", 0, 32'(done2), 0);
        rst2 = 1'b1;
        tick();
        chk("w_post_done", 0, 32'(done2), 0);
        chk("w_post_regime", 0, 32'(regime2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
